// File: rtl/mna_response_sequencer.sv
// mna_response_sequencer: turns NoC response flits into AXI4-Lite B/R responses, one at a time.
// Optional payload timeout built only when MNA_RESP_TIMEOUT_EN is defined.
module mna_response_sequencer #(
    parameter int FLIT_W      = 37,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] noc_data,
    input  logic              noc_valid,
    output logic              noc_ready,
    output logic              bvalid,
    input  logic              bready,
    output logic [1:0]        bresp,
    output logic              rvalid,
    input  logic              rready,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              flit_err
);
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DATA = 2'd1;
    localparam logic [1:0] B_OUT     = 2'd2;
    localparam logic [1:0] R_OUT     = 2'd3;
    localparam logic [1:0] T_HDR     = 2'b10;
    localparam logic [1:0] T_PLD     = 2'b01;

    logic [1:0]        state_q, state_d;
    logic              noc_ready_q, noc_ready_d;
    logic              bvalid_q, bvalid_d;
    logic              rvalid_q, rvalid_d;
    logic              flit_err_q, flit_err_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [1:0]        rresp_q, rresp_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              acc, is_hdr, is_pld, unused_bits;

    assign acc    = noc_valid & noc_ready_q;
    assign is_hdr = noc_data[FLIT_W-1:FLIT_W-2] == T_HDR;
    assign is_pld = noc_data[FLIT_W-1:FLIT_W-2] == T_PLD;
    assign unused_bits = ^{noc_data[FLIT_W-3:DATA_W], TIMEOUT_CYC != 0};

`ifdef MNA_RESP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYC);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    always_comb begin
        state_d    = state_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        flit_err_d = 1'b0;
        case (state_q)
            IDLE, WAIT_DATA: begin
                if (acc && is_hdr) begin
                    // a header while a read is pending abandons that read
                    flit_err_d = state_q == WAIT_DATA;
                    if (noc_data[0]) begin
                        bresp_d = noc_data[2:1];
                        state_d = B_OUT;
                    end else begin
                        rresp_d = noc_data[2:1];
                        state_d = WAIT_DATA;
                    end
                end else if (acc && is_pld && state_q == WAIT_DATA) begin
                    rdata_d = noc_data[DATA_W-1:0];
                    state_d = R_OUT;
                end else if (acc) begin
                    flit_err_d = 1'b1;
                end
            end
            B_OUT:   state_d = bready ? IDLE : B_OUT;
            default: state_d = rready ? IDLE : R_OUT;
        endcase
`ifdef MNA_RESP_TIMEOUT_EN
        cnt_d = '0;
        if (state_q == WAIT_DATA && state_d == WAIT_DATA && !(acc && is_hdr)) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == TMO) begin
                state_d    = R_OUT;
                rdata_d    = '0;
                rresp_d    = 2'b10;
                flit_err_d = 1'b1;
            end
        end
`endif
        noc_ready_d = state_d == IDLE || state_d == WAIT_DATA;
        bvalid_d    = state_d == B_OUT;
        rvalid_d    = state_d == R_OUT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            noc_ready_q <= 1'b0;
            bvalid_q    <= 1'b0;
            rvalid_q    <= 1'b0;
            flit_err_q  <= 1'b0;
            bresp_q     <= 2'b00;
            rresp_q     <= 2'b00;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            noc_ready_q <= noc_ready_d;
            bvalid_q    <= bvalid_d;
            rvalid_q    <= rvalid_d;
            flit_err_q  <= flit_err_d;
            bresp_q     <= bresp_d;
            rresp_q     <= rresp_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MNA_RESP_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif

    assign noc_ready = noc_ready_q;
    assign bvalid    = bvalid_q;
    assign rvalid    = rvalid_q;
    assign flit_err  = flit_err_q;
    assign bresp     = bresp_q;
    assign rresp     = rresp_q;
    assign rdata     = rdata_q;
endmodule

// File: tb/tb_mna_response_sequencer.sv
// tb_mna_response_sequencer: directed checks of the MNA response sequencer (default build).
module tb_mna_response_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [36:0] noc_data = '0;
    logic        noc_valid = 1'b0;
    logic        noc_ready;
    logic        bvalid, bready = 1'b0;
    logic [1:0]  bresp;
    logic        rvalid, rready = 1'b0;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        flit_err;
    int          checks = 0;
    int          failures = 0;

    mna_response_sequencer dut (
        .clk(clk), .rst(rst), .noc_data(noc_data), .noc_valid(noc_valid), .noc_ready(noc_ready),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .rvalid(rvalid), .rready(rready),
        .rdata(rdata), .rresp(rresp), .flit_err(flit_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_noc_ready", noc_ready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_flit_err", flit_err, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_resp", {bresp, rresp}, 0);
        step();
        rst = 1'b0;
        step();
        chk("idle_noc_ready", noc_ready, 1);

        // write response
        noc_data = 37'h10_0000_0003; noc_valid = 1'b1; bready = 1'b1;
        step();
        noc_valid = 1'b0;
        chk("wr_bvalid", bvalid, 1);
        chk("wr_bresp", bresp, 2'b01);
        chk("wr_noc_ready", noc_ready, 0);
        step();
        chk("wr_bvalid_fall", bvalid, 0);
        chk("wr_noc_ready_back", noc_ready, 1);
        bready = 1'b0;

        // read response with rready held low
        noc_data = 37'h10_0000_0000; noc_valid = 1'b1;
        step();
        chk("rd_wait_rvalid", rvalid, 0);
        chk("rd_wait_noc_ready", noc_ready, 1);
        noc_data = 37'h08_DEAD_BEEF;
        step();
        noc_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rd_rvalid", rvalid, 1);
            chk("rd_rdata", rdata, 32'hDEADBEEF);
            chk("rd_rresp", rresp, 2'b00);
            chk("rd_noc_ready", noc_ready, 0);
            if (i < 2) step();
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rd_done_rvalid", rvalid, 0);
        chk("rd_done_noc_ready", noc_ready, 1);
        chk("rd_rdata_kept", rdata, 32'hDEADBEEF);

        // stray payload in IDLE
        noc_data = 37'h08_0000_1234; noc_valid = 1'b1;
        step();
        noc_valid = 1'b0;
        chk("stray_err", flit_err, 1);
        chk("stray_valids", {bvalid, rvalid}, 0);
        chk("stray_noc_ready", noc_ready, 1);
        step();
        chk("stray_err_fall", flit_err, 0);

        // back-to-back illegal flits
        noc_data = 37'h18_0000_0000; noc_valid = 1'b1;
        step();
        chk("ill_err1", flit_err, 1);
        noc_data = 37'h00_0000_0000;
        step();
        noc_valid = 1'b0;
        chk("ill_err2", flit_err, 1);
        step();
        chk("ill_err_fall", flit_err, 0);

        // header in WAIT_DATA
        noc_data = 37'h10_0000_0000; noc_valid = 1'b1;
        step();
        noc_data = 37'h10_0000_0005;
        step();
        noc_valid = 1'b0;
        chk("hh_err", flit_err, 1);
        chk("hh_bvalid", bvalid, 1);
        chk("hh_bresp", bresp, 2'b10);
        chk("hh_rvalid", rvalid, 0);
        step();
        chk("hh_bvalid_hold", bvalid, 1);
        chk("hh_bresp_hold", bresp, 2'b10);
        chk("hh_err_fall", flit_err, 0);
        bready = 1'b1;
        step();
        bready = 1'b0;
        chk("hh_bvalid_fall", bvalid, 0);
        chk("hh_bresp_kept", bresp, 2'b10);

        // async reset in R_OUT
        noc_data = 37'h10_0000_0000; noc_valid = 1'b1;
        step();
        noc_data = 37'h08_1234_5678;
        step();
        noc_valid = 1'b0;
        chk("ar_rvalid", rvalid, 1);
        chk("ar_rdata", rdata, 32'h12345678);
        #2 rst = 1'b1;
        #1;
        chk("ar_rvalid_0", rvalid, 0);
        chk("ar_noc_ready_0", noc_ready, 0);
        chk("ar_rdata_0", rdata, 0);
        step();
        rst = 1'b0;
        step();
        chk("ar_noc_ready_1", noc_ready, 1);
        noc_data = 37'h10_0000_0001; noc_valid = 1'b1; bready = 1'b1;
        step();
        noc_valid = 1'b0;
        chk("ar_wr_bvalid", bvalid, 1);
        chk("ar_wr_bresp", bresp, 2'b00);
        step();
        chk("ar_wr_bvalid_fall", bvalid, 0);
        chk("ar_wr_noc_ready", noc_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mna_response_sequencer.md
Name: mna_response_sequencer

Overview:
- Sequences the MNA response flow. Accepts NoC response flits (header, then payload for reads), extracts response fields, and drives the AXI4-Lite B or R channel toward the master.
- Sits between the NoC ejection port and the AXI4-Lite master-side response channels.
- Holds at most one response at a time. Applies backpressure to the NoC while an AXI response is pending.

Parameters:
- FLIT_W, 37, flit width: [36:35] type, [31:0] body.
- DATA_W, 32, AXI read data width; must equal 32.
- TIMEOUT_CYC, 64, payload wait limit in cycles; used only with MNA_RESP_TIMEOUT_EN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- noc_data  in  37  response flit.
- noc_valid  in  1  flit valid.
- noc_ready  out  1  flit accepted when noc_valid & noc_ready.
- bvalid  out  1  AXI write response valid.
- bready  in  1  AXI write response ready.
- bresp  out  2  AXI write response code.
- rvalid  out  1  AXI read data valid.
- rready  in  1  AXI read data ready.
- rdata  out  32  AXI read data.
- rresp  out  2  AXI read response code.
- flit_err  out  1  one-cycle pulse on protocol violation.

Behaviour:
- Clock and reset: one clock (clk). rst is asynchronous, active-high.
- Flit types in [36:35]:
  - 2'b10 header: [0] write flag (1 = write response, 0 = read response); [2:1] resp code.
  - 2'b01 payload: [31:0] read data.
  - 2'b00 and 2'b11 are illegal.
- Reset state: IDLE. All outputs 0 (noc_ready, bvalid, rvalid, flit_err, bresp, rresp, rdata). Reset mid-operation discards any partial or pending response.
- FSM states: IDLE, WAIT_DATA, B_OUT, R_OUT.
- noc_ready is registered: 1 in IDLE and WAIT_DATA, 0 in B_OUT and R_OUT.
- IDLE:
  - Header, write=1: latch bresp=[2:1]; go to B_OUT. bvalid=1 the cycle after acceptance (1-cycle latency).
  - Header, write=0: latch rresp=[2:1]; go to WAIT_DATA.
  - Payload or illegal type: flit dropped; flit_err pulse next cycle; stay IDLE.
- WAIT_DATA:
  - Payload: latch rdata=[31:0]; go to R_OUT. rvalid=1 the cycle after acceptance.
  - Header: flit_err pulse. The stored read is abandoned and the new header is processed exactly as in IDLE.
  - Illegal type: flit_err pulse; flit dropped; stay in WAIT_DATA.
- B_OUT:
  - bvalid and bresp held stable until bready=1.
  - On the bvalid & bready cycle: bvalid falls next cycle; go to IDLE; noc_ready=1 next cycle.
- R_OUT:
  - rvalid, rdata and rresp held stable until rready=1.
  - On the rvalid & rready cycle: go to IDLE.
- No combinational path from bready or rready to noc_ready. Minimum header-to-header spacing for write responses is 2 cycles.
- A ready already high before valid rises completes the handshake in the first valid cycle.
- rdata and rresp keep their last value after handshake. bresp likewise.
- flit_err is a single-cycle pulse per offending flit. Back-to-back errors produce back-to-back pulses.

Optional Feature:
MNA_RESP_TIMEOUT_EN
- Defined:
  - A counter clears on entry to WAIT_DATA and increments each cycle in WAIT_DATA without an accepted payload.
  - When it reaches TIMEOUT_CYC: go to R_OUT with rdata=0, rresp=2'b10 (SLVERR), and flit_err pulse.
  - A payload accepted in the same cycle the count is reached wins: normal data, no error.
- Undefined: no counter is built; WAIT_DATA waits indefinitely.

Test Plan:
- Write response: header 37'h10_0000_0003 (write=1, resp=01), bready=1 → bvalid=1 with bresp=2'b01 one cycle after acceptance, for exactly 1 cycle; noc_ready=0 during B_OUT.
- Read response: header 37'h10_0000_0000, then payload 37'h08_DEAD_BEEF, rready held 0 for 3 cycles → rvalid=1, rdata=32'hDEADBEEF, rresp=00, all stable 3 cycles; then rready=1 → IDLE, noc_ready=1.
- Stray payload 37'h08_0000_1234 in IDLE → dropped, flit_err pulse, no valid asserted, state IDLE.
- Header 37'h10_0000_0000 then header 37'h10_0000_0005 in WAIT_DATA → flit_err pulse, bvalid=1 with bresp=2'b10.
- Assert rst asynchronously while in R_OUT with rvalid=1 → rvalid, noc_ready and rdata go 0 immediately; after release, a fresh write header completes normally.
- With MNA_RESP_TIMEOUT_EN, TIMEOUT_CYC=8: read header, no payload → rvalid=1 after 8 wait cycles, rdata=0, rresp=2'b10, flit_err pulse.
